// File: rtl/axil_ram_arbiter_if.sv
// axil_ram_arbiter_if: two request/response client ports plus the AXI4-Lite master port of the arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface axil_ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  c0_req_valid, c0_req_ready, c0_req_we;
    logic [ADDR_WIDTH-1:0] c0_req_addr;
    logic [DATA_WIDTH-1:0] c0_req_wdata;
    logic [STRB_WIDTH-1:0] c0_req_wstrb;
    logic                  c0_rsp_valid;
    logic [DATA_WIDTH-1:0] c0_rsp_rdata;
    logic [1:0]            c0_rsp_resp;
    logic                  c1_req_valid, c1_req_ready, c1_req_we;
    logic [ADDR_WIDTH-1:0] c1_req_addr;
    logic [DATA_WIDTH-1:0] c1_req_wdata;
    logic [STRB_WIDTH-1:0] c1_req_wstrb;
    logic                  c1_rsp_valid;
    logic [DATA_WIDTH-1:0] c1_rsp_rdata;
    logic [1:0]            c1_rsp_resp;
    logic [ADDR_WIDTH-1:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]            m_axil_awprot, m_axil_arprot;
    logic                  m_axil_awvalid, m_axil_awready;
    logic [DATA_WIDTH-1:0] m_axil_wdata, m_axil_rdata;
    logic [STRB_WIDTH-1:0] m_axil_wstrb;
    logic                  m_axil_wvalid, m_axil_wready;
    logic [1:0]            m_axil_bresp, m_axil_rresp;
    logic                  m_axil_bvalid, m_axil_bready;
    logic                  m_axil_arvalid, m_axil_arready;
    logic                  m_axil_rvalid, m_axil_rready;

    modport master (
        input  c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata, c0_req_wstrb,
        input  c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata, c1_req_wstrb,
        output c0_req_ready, c0_rsp_valid, c0_rsp_rdata, c0_rsp_resp,
        output c1_req_ready, c1_rsp_valid, c1_rsp_rdata, c1_rsp_resp,
        output m_axil_awaddr, m_axil_awprot, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        output m_axil_bready, m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
        input  m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
        input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid
    );

    modport slave (
        output c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata, c0_req_wstrb,
        output c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata, c1_req_wstrb,
        input  c0_req_ready, c0_rsp_valid, c0_rsp_rdata, c0_rsp_resp,
        input  c1_req_ready, c1_rsp_valid, c1_rsp_rdata, c1_rsp_resp,
        input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        input  m_axil_bready, m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
        output m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
        output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid
    );
endinterface

// File: rtl/axil_ram_arbiter.sv
// axil_ram_arbiter: shares one AXI4-Lite slave between two single-beat request/response clients.
// Define AXIL_ARB_RR_EN for round-robin arbitration; otherwise client 0 has fixed priority.
module axil_ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input logic clk,
    input logic rst,
    axil_ram_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, RSP} state_t;

    state_t                r_state, w_next;
    logic                  r_gnt, r_aw_done, r_w_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0] r_rdata [2];
    logic [1:0]            r_resp [2];
    logic                  w_gnt, w_accept, w_aw_ok, w_w_ok;

`ifdef AXIL_ARB_RR_EN
    logic r_last;
    assign w_gnt = (bus.c0_req_valid && bus.c1_req_valid) ? !r_last : !bus.c0_req_valid;
    always_ff @(posedge clk)
        if (rst) r_last <= 1'b1;
        else if (w_accept) r_last <= w_gnt;
`else
    assign w_gnt = !bus.c0_req_valid;
`endif

    // Gating with rst keeps req_ready low while held in reset.
    assign w_accept = !rst && r_state == IDLE && (bus.c0_req_valid || bus.c1_req_valid);
    assign w_aw_ok  = r_aw_done || (bus.m_axil_awvalid && bus.m_axil_awready);
    assign w_w_ok   = r_w_done || (bus.m_axil_wvalid && bus.m_axil_wready);

    assign bus.c0_req_ready  = w_accept && !w_gnt;
    assign bus.c1_req_ready  = w_accept && w_gnt;
    assign bus.c0_rsp_rdata  = r_rdata[0];
    assign bus.c1_rsp_rdata  = r_rdata[1];
    assign bus.c0_rsp_resp   = r_resp[0];
    assign bus.c1_rsp_resp   = r_resp[1];
    assign bus.m_axil_awaddr = r_addr;
    assign bus.m_axil_araddr = r_addr;
    assign bus.m_axil_awprot = 3'b000;
    assign bus.m_axil_arprot = 3'b000;
    assign bus.m_axil_wdata  = r_wdata;
    assign bus.m_axil_wstrb  = r_wstrb;

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (w_gnt ? bus.c1_req_we : bus.c0_req_we) ? WRITE : READ;
            WRITE:   if (w_aw_ok && w_w_ok) w_next = WRESP;
            WRESP:   if (bus.m_axil_bvalid) w_next = RSP;
            READ:    if (bus.m_axil_arready) w_next = RRESP;
            RRESP:   if (bus.m_axil_rvalid) w_next = RSP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.m_axil_awvalid = r_state == WRITE && !r_aw_done;
        bus.m_axil_wvalid  = r_state == WRITE && !r_w_done;
        bus.m_axil_bready  = r_state == WRESP;
        bus.m_axil_arvalid = r_state == READ;
        bus.m_axil_rready  = r_state == RRESP;
        bus.c0_rsp_valid   = r_state == RSP && !r_gnt;
        bus.c1_rsp_valid   = r_state == RSP && r_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '{default: '0};
            r_resp    <= '{default: '0};
        end else begin
            if (w_accept) begin
                r_gnt   <= w_gnt;
                r_addr  <= w_gnt ? bus.c1_req_addr : bus.c0_req_addr;
                r_wdata <= w_gnt ? bus.c1_req_wdata : bus.c0_req_wdata;
                r_wstrb <= w_gnt ? bus.c1_req_wstrb : bus.c0_req_wstrb;
            end
            // A done flag survives only while its partner channel is still pending.
            r_aw_done <= r_state == WRITE && w_aw_ok && !w_w_ok;
            r_w_done  <= r_state == WRITE && w_w_ok && !w_aw_ok;
            if (r_state == WRESP && bus.m_axil_bvalid) begin
                r_rdata[r_gnt] <= '0;
                r_resp[r_gnt]  <= bus.m_axil_bresp;
            end
            if (r_state == RRESP && bus.m_axil_rvalid) begin
                r_rdata[r_gnt] <= bus.m_axil_rdata;
                r_resp[r_gnt]  <= bus.m_axil_rresp;
            end
        end
    end
endmodule

// File: tb/tb_axil_ram_arbiter.sv
// tb_axil_ram_arbiter: directed bench with a small AXI4-Lite RAM responder whose AW ready can be stalled.
module tb_axil_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b ();
    axil_ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(b));

    int          checks = 0;
    int          errors = 0;
    int          aw_stall_cfg = 0;
    logic [1:0]  resp_cfg = 2'b00;

    logic [31:0] mem [8];
    int          aw_wait;
    logic        aw_got, w_got;
    logic [4:0]  aw_a, addr_c;
    logic [31:0] w_d, wd_c;
    logic [3:0]  w_s, ws_c;
    logic        s_aw_hs, s_w_hs, s_ar_hs;

    assign b.m_axil_awready = aw_wait >= aw_stall_cfg;
    assign b.m_axil_wready  = 1'b1;
    assign b.m_axil_arready = 1'b1;
    assign b.m_axil_bresp   = resp_cfg;
    assign b.m_axil_rresp   = resp_cfg;
    assign s_aw_hs = b.m_axil_awvalid && b.m_axil_awready;
    assign s_w_hs  = b.m_axil_wvalid && b.m_axil_wready;
    assign s_ar_hs = b.m_axil_arvalid && b.m_axil_arready;
    assign addr_c  = s_aw_hs ? b.m_axil_awaddr : aw_a;
    assign wd_c    = s_w_hs ? b.m_axil_wdata : w_d;
    assign ws_c    = s_w_hs ? b.m_axil_wstrb : w_s;

    always @(posedge clk) begin
        if (rst) begin
            aw_wait         <= 0;
            aw_got          <= 1'b0;
            w_got           <= 1'b0;
            b.m_axil_bvalid <= 1'b0;
            b.m_axil_rvalid <= 1'b0;
            b.m_axil_rdata  <= '0;
        end else begin
            if (s_aw_hs) begin
                aw_got  <= 1'b1;
                aw_a    <= b.m_axil_awaddr;
                aw_wait <= 0;
            end else if (b.m_axil_awvalid) aw_wait <= aw_wait + 1;
            if (s_w_hs) begin
                w_got <= 1'b1;
                w_d   <= b.m_axil_wdata;
                w_s   <= b.m_axil_wstrb;
            end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
                for (int i = 0; i < 4; i++)
                    if (ws_c[i]) mem[addr_c[4:2]][8*i +: 8] <= wd_c[8*i +: 8];
                b.m_axil_bvalid <= 1'b1;
                aw_got          <= 1'b0;
                w_got           <= 1'b0;
            end else if (b.m_axil_bvalid && b.m_axil_bready) b.m_axil_bvalid <= 1'b0;
            if (s_ar_hs) begin
                b.m_axil_rvalid <= 1'b1;
                b.m_axil_rdata  <= mem[b.m_axil_araddr[4:2]];
            end else if (b.m_axil_rvalid && b.m_axil_rready) b.m_axil_rvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (n == 0) begin
            b.c0_req_valid = v; b.c0_req_we = we; b.c0_req_addr = a; b.c0_req_wdata = d; b.c0_req_wstrb = s;
        end else begin
            b.c1_req_valid = v; b.c1_req_we = we; b.c1_req_addr = a; b.c1_req_wdata = d; b.c1_req_wstrb = s;
        end
    endtask

    function automatic logic rdy(input int n);
        return (n != 0) ? b.c1_req_ready : b.c0_req_ready;
    endfunction
    function automatic logic rv(input int n);
        return (n != 0) ? b.c1_rsp_valid : b.c0_rsp_valid;
    endfunction
    function automatic logic [31:0] rdat(input int n);
        return (n != 0) ? b.c1_rsp_rdata : b.c0_rsp_rdata;
    endfunction
    function automatic logic [1:0] rres(input int n);
        return (n != 0) ? b.c1_rsp_resp : b.c0_rsp_resp;
    endfunction

    // Called at a negedge with the arbiter idle; returns at the negedge after the response pulse.
    task automatic xact(input string tag, input int n, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rd, input logic [1:0] exp_rp, input int exp_lat);
        int   lat;
        logic other;
        set_req(n, 1'b1, we, a, d, s);
        #1;
        chk({tag, "_ready"}, rdy(n), 1);
        chk({tag, "_other_ready"}, rdy(1 - n), 0);
        @(negedge clk);
        set_req(n, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        lat = 1;
        other = 1'b0;
        while (!rv(n) && lat < 40) begin
            other |= rv(1 - n);
            @(negedge clk);
            lat++;
        end
        other |= rv(1 - n);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rdata"}, rdat(n), exp_rd);
        chk({tag, "_resp"}, rres(n), exp_rp);
        chk({tag, "_other_rsp"}, other, 0);
        @(negedge clk);
        chk({tag, "_pulse_width"}, rv(n), 0);
    endtask

    initial begin
        logic       seen;
        logic [3:0] g;
        logic [3:0] exp_g;
        int         cnt, cyc;
        set_req(0, 1'b1, 1'($urandom), 5'($urandom), $urandom, 4'($urandom));
        set_req(1, 1'b1, 1'($urandom), 5'($urandom), $urandom, 4'($urandom));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ctrl", {b.c0_req_ready, b.c1_req_ready, b.c0_rsp_valid, b.c1_rsp_valid, b.m_axil_awvalid,
                             b.m_axil_wvalid, b.m_axil_bready, b.m_axil_arvalid, b.m_axil_rready}, 0);
            chk("rst_rdata", {b.c0_rsp_rdata, b.c1_rsp_rdata}, 0);
            chk("rst_bus", {b.m_axil_awaddr, b.m_axil_araddr, b.m_axil_wdata, b.m_axil_wstrb, b.m_axil_awprot,
                            b.m_axil_arprot, b.c0_rsp_resp, b.c1_rsp_resp}, 0);
        end
        set_req(0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        xact("wr04", 0, 1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 3);
        xact("rd04", 0, 1'b0, 5'h04, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 3);

        xact("wr08_full", 1, 1'b1, 5'h08, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00, 3);
        xact("wr08_part", 1, 1'b1, 5'h08, 32'h000000AA, 4'h1, 32'h0, 2'b00, 3);
        xact("rd08", 1, 1'b0, 5'h08, 32'h0, 4'h0, 32'hFFFFFFAA, 2'b00, 3);
        repeat (3) @(negedge clk);
        chk("rdata_hold", b.c1_rsp_rdata, 32'hFFFFFFAA);

        aw_stall_cfg = 3;
        resp_cfg = 2'b10;
        set_req(0, 1'b1, 1'b1, 5'h10, 32'h12345678, 4'hF);
        #1;
        chk("skew_ready", b.c0_req_ready, 1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        chk("skew_t1", {b.m_axil_awvalid, b.m_axil_wvalid, b.m_axil_bready, b.c0_rsp_valid}, 4'b1100);
        @(negedge clk);
        chk("skew_t2", {b.m_axil_awvalid, b.m_axil_wvalid, b.m_axil_bready, b.c0_rsp_valid}, 4'b1000);
        @(negedge clk);
        chk("skew_t3", {b.m_axil_awvalid, b.m_axil_wvalid, b.m_axil_bready, b.c0_rsp_valid}, 4'b1000);
        @(negedge clk);
        chk("skew_t4", {b.m_axil_awvalid, b.m_axil_wvalid, b.m_axil_bready, b.c0_rsp_valid}, 4'b1000);
        chk("skew_awaddr", b.m_axil_awaddr, 5'h10);
        @(negedge clk);
        chk("skew_t5", {b.m_axil_awvalid, b.m_axil_wvalid, b.m_axil_bready, b.c0_rsp_valid}, 4'b0010);
        @(negedge clk);
        chk("skew_t6", {b.m_axil_awvalid, b.m_axil_wvalid, b.m_axil_bready, b.c0_rsp_valid}, 4'b0001);
        chk("skew_resp", {b.c0_rsp_rdata, b.c0_rsp_resp}, {32'h0, 2'b10});
        @(negedge clk);
        chk("skew_t7", {b.c0_rsp_valid, b.c1_rsp_valid}, 2'b00);
        aw_stall_cfg = 0;
        resp_cfg = 2'b00;

        set_req(0, 1'b1, 1'b1, 5'h14, 32'h00000055, 4'hF);
        #1;
        chk("mid_ready", b.c0_req_ready, 1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("mid_wresp", b.m_axil_bready, 1);
        rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= b.c0_rsp_valid | b.c1_rsp_valid;
        end
        chk("mid_rst_rdata", {b.c0_rsp_rdata, b.c1_rsp_rdata}, 0);
        chk("mid_rst_ctrl", {b.m_axil_bready, b.m_axil_awvalid, b.m_axil_wvalid, b.c0_rsp_resp}, 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= b.c0_rsp_valid | b.c1_rsp_valid;
        end
        chk("mid_no_rsp", seen, 0);
        xact("rst_rd04", 1, 1'b0, 5'h04, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 3);

`ifdef AXIL_ARB_RR_EN
        exp_g = 4'b1010;
`else
        exp_g = 4'b0000;
`endif
        set_req(0, 1'b1, 1'b1, 5'h18, 32'hC0C0C0C0, 4'hF);
        set_req(1, 1'b1, 1'b1, 5'h1C, 32'hC1C1C1C1, 4'hF);
        g = 4'h0;
        cnt = 0;
        cyc = 0;
        while (cnt < 4 && cyc < 100) begin
            #1;
            if (b.c0_req_ready) begin
                g[cnt] = 1'b0;
                cnt++;
            end else if (b.c1_req_ready) begin
                g[cnt] = 1'b1;
                cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("cont_count", cnt, 4);
        chk("cont_order", g, exp_g);
        set_req(0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
